// File: rtl/resp_tx_seq.sv
// Frame sequencer feeding an 8-bit UART transmitter: cmd, data[15:8], data[7:0]
// and an optional inverted-sum checksum, one byte per trmt/tx_done handshake.
module resp_tx_seq #(
  parameter int CHKSUM_EN = 1,
  parameter int GAP_CYC   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frm_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [1:0] LAST_IDX = (CHKSUM_EN != 0) ? 2'd3 : 2'd2;
  localparam logic [7:0] GAP_LAST = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic [7:0]  cmd_reg, cmd_next;
  logic [15:0] data_reg, data_next;
  logic        busy_reg, busy_next;
  logic        frm_done_reg, frm_done_next;
  logic        trmt_reg;
  logic [7:0]  tx_data_reg;
  logic        done_prev_reg;
  logic        tx_rise;

  logic [23:0] payload_next;
  logic [7:0]  frm_byte [4];

  // Only a fresh rising edge counts: the done flag is still high from the
  // previous byte for a cycle or so after trmt.
  assign tx_rise = tx_done & ~done_prev_reg;

  // Frame bytes come from the next-state latch so the first byte can be
  // presented on the same edge that accepts snd.
  assign payload_next = {cmd_next, data_next};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_byte
    assign frm_byte[gi] = payload_next[23 - 8*gi -: 8];
  end
  assign frm_byte[3] = ~(frm_byte[0] + frm_byte[1] + frm_byte[2]);

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    gap_cnt_next  = gap_cnt_reg;
    cmd_next      = cmd_reg;
    data_next     = data_reg;
    busy_next     = busy_reg;
    frm_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (snd) begin
          cmd_next   = cmd;
          data_next  = data;
          idx_next   = 2'd0;
          busy_next  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: state_next = WAIT;
      WAIT: begin
        if (tx_rise) begin
          if (idx_reg == LAST_IDX) begin
            state_next    = IDLE;
            busy_next     = 1'b0;
            frm_done_next = 1'b1;
          end else begin
            idx_next     = idx_reg + 2'd1;
            gap_cnt_next = 8'd0;
            state_next   = (GAP_CYC > 0) ? GAP : LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = LOAD;
        else gap_cnt_next = gap_cnt_reg + 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= 2'd0;
      gap_cnt_reg   <= 8'd0;
      cmd_reg       <= 8'h00;
      data_reg      <= 16'h0000;
      busy_reg      <= 1'b0;
      frm_done_reg  <= 1'b0;
      trmt_reg      <= 1'b0;
      tx_data_reg   <= 8'h00;
      done_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      gap_cnt_reg   <= gap_cnt_next;
      cmd_reg       <= cmd_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
      frm_done_reg  <= frm_done_next;
      done_prev_reg <= tx_done;
      // trmt is high exactly for the cycle spent in LOAD.
      trmt_reg      <= (state_next == LOAD);
      if (state_next == LOAD) tx_data_reg <= frm_byte[idx_next];
    end
  end

  assign trmt     = trmt_reg;
  assign tx_data  = tx_data_reg;
  assign busy     = busy_reg;
  assign frm_done = frm_done_reg;

endmodule

// File: tb/tb_resp_tx_seq.sv
// Directed bench for resp_tx_seq: three configurations, each driving a small
// UART transmitter model; the checksum configuration also feeds a serial decoder.
module tb_resp_tx_seq;

  localparam int BIT = 4;   // clocks per serial bit in the transmitter model

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        snd_w      [3];
  logic        trmt_w     [3];
  logic [7:0]  tx_data_w  [3];
  logic        busy_w     [3];
  logic        frm_done_w [3];
  logic        tx_done_w  [3];
  logic        line_w     [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: checksum, no gap. 1: no checksum. 2: checksum, 10-clock gap.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    logic       tx_act;
    int         tx_cnt;
    logic [9:0] tx_sh;
    logic       tx_done_m;

    resp_tx_seq #(
      .CHKSUM_EN((gi == 1) ? 0 : 1),
      .GAP_CYC  ((gi == 2) ? 10 : 0)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .snd     (snd_w[gi]),
      .cmd     (cmd),
      .data    (data),
      .tx_done (tx_done_m),
      .trmt    (trmt_w[gi]),
      .tx_data (tx_data_w[gi]),
      .busy    (busy_w[gi]),
      .frm_done(frm_done_w[gi])
    );

    // Transmitter: done drops one clock after trmt is taken, so the
    // sequencer sees a stale high done in its first WAIT cycle.
    always @(posedge clk) begin
      if (rst) begin
        tx_act    <= 1'b0;
        tx_cnt    <= 0;
        tx_sh     <= '1;
        tx_done_m <= 1'b1;
      end else if (!tx_act) begin
        if (trmt_w[gi]) begin
          tx_act <= 1'b1;
          tx_cnt <= 0;
          tx_sh  <= {1'b1, tx_data_w[gi], 1'b0};
        end
      end else begin
        tx_cnt <= tx_cnt + 1;
        if (tx_cnt == 0) tx_done_m <= 1'b0;
        if (tx_cnt % BIT == BIT - 1) tx_sh <= {1'b1, tx_sh[9:1]};
        if (tx_cnt == 10*BIT - 1) begin
          tx_act    <= 1'b0;
          tx_done_m <= 1'b1;
        end
      end
    end

    assign tx_done_w[gi] = tx_done_m;
    assign line_w[gi]    = tx_sh[0];
  end

  // Serial decoder on instance 0, sampling mid-bit.
  logic       mon_act = 1'b0;
  int         mcnt = 0;
  logic [7:0] msh = 8'h00;
  logic [7:0] rx_q [$];

  always @(posedge clk) begin
    if (rst) begin
      mon_act <= 1'b0;
    end else if (!mon_act) begin
      if (!line_w[0]) begin
        mon_act <= 1'b1;
        mcnt    <= 1;
      end
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt % BIT == BIT/2 && mcnt >= BIT && mcnt < 9*BIT) msh <= {line_w[0], msh[7:1]};
      if (mcnt == 9*BIT + BIT/2) begin
        mon_act <= 1'b0;
        rx_q.push_back(msh);
      end
    end
  end

  logic [7:0] byte_q  [$];
  int         trmt_cq [$];
  int         rise_cq [$];
  int         done_cnt, done_cyc, busy_drop, overlap, extra_trmt, extra_done;

  task automatic pulse_snd(input int inst, input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    cmd = c;
    data = d;
    snd_w[inst] = 1'b1;
    @(negedge clk);
    snd_w[inst] = 1'b0;
  endtask

  // Records one frame starting at the current negedge, then watches a tail.
  task automatic collect(input int inst, input int budget, input int tail);
    logic prev_td;
    bit   seen;
    byte_q.delete();
    trmt_cq.delete();
    rise_cq.delete();
    done_cnt = 0; done_cyc = 0; busy_drop = 0; overlap = 0;
    extra_trmt = 0; extra_done = 0;
    prev_td = 1'b1;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (trmt_w[inst]) begin
        byte_q.push_back(tx_data_w[inst]);
        trmt_cq.push_back(cyc);
      end
      if (tx_done_w[inst] && !prev_td) rise_cq.push_back(cyc);
      prev_td = tx_done_w[inst];
      if (!busy_w[inst] && !frm_done_w[inst]) busy_drop++;
      if (frm_done_w[inst]) begin
        done_cnt++;
        done_cyc = cyc;
        if (trmt_w[inst]) overlap++;
        seen = 1;
      end
      if (!seen) @(negedge clk);
    end
    for (int i = 0; i < tail; i++) begin
      @(negedge clk);
      if (trmt_w[inst]) extra_trmt++;
      if (frm_done_w[inst]) extra_done++;
    end
    $display("frame inst%0d: bytes=%0d frm_done=%0d extra_trmt=%0d", inst, byte_q.size(), done_cnt, extra_trmt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({trmt_w[i], busy_w[i], frm_done_w[i], tx_data_w[i]} !== 11'h000) begin
        bad++;
        $display("FAIL reset_outputs inst%0d: got %h want 000", i,
                 {trmt_w[i], busy_w[i], frm_done_w[i], tx_data_w[i]});
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_chksum();
    logic [7:0] exp_b [4] = '{8'hA5, 8'h12, 8'h34, 8'h14};
    rx_q.delete();
    pulse_snd(0, 8'hA5, 16'h1234);
    total++;
    if (trmt_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL latency_trmt: got %b want 1", trmt_w[0]);
    end
    collect(0, 400, 20);
    total++;
    if (byte_q.size() != 4) begin
      bad++;
      $display("FAIL chk_count: got %0d want 4", byte_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (byte_q[k] !== exp_b[k]) begin
        bad++;
        $display("FAIL chk_byte%0d: got %h want %h", k, byte_q[k], exp_b[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (trmt_cq[k+1] - trmt_cq[k] != 42) begin
        bad++;
        $display("FAIL chk_spacing%0d: got %0d want 42", k, trmt_cq[k+1] - trmt_cq[k]);
      end
    end
    total++;
    if (done_cnt != 1 || done_cyc != rise_cq[3] + 1) begin
      bad++;
      $display("FAIL chk_frm_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, rise_cq[3] + 1);
    end
    total++;
    if (busy_drop != 0 || overlap != 0 || extra_trmt != 0 || extra_done != 0) begin
      bad++;
      $display("FAIL chk_busy_extra: got drop=%0d ovl=%0d xt=%0d xd=%0d want 0 0 0 0",
               busy_drop, overlap, extra_trmt, extra_done);
    end
    total++;
    if (tx_data_w[0] !== 8'h14) begin
      bad++;
      $display("FAIL chk_tx_data_hold: got %h want 14", tx_data_w[0]);
    end
    total++;
    if (rx_q.size() != 4) begin
      bad++;
      $display("FAIL loopback_count: got %0d want 4", rx_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rx_q[k] !== exp_b[k]) begin
        bad++;
        $display("FAIL loopback_byte%0d: got %h want %h", k, rx_q[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_no_chksum();
    logic [7:0] exp_b [3] = '{8'h05, 8'hFF, 8'hFF};
    pulse_snd(1, 8'h05, 16'hFFFF);
    collect(1, 400, 60);
    total++;
    if (byte_q.size() != 3 || extra_trmt != 0) begin
      bad++;
      $display("FAIL nochk_count: got %0d+%0d want 3+0", byte_q.size(), extra_trmt);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (byte_q[k] !== exp_b[k]) begin
        bad++;
        $display("FAIL nochk_byte%0d: got %h want %h", k, byte_q[k], exp_b[k]);
      end
    end
    total++;
    if (done_cnt != 1 || done_cyc != rise_cq[2] + 1) begin
      bad++;
      $display("FAIL nochk_frm_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, rise_cq[2] + 1);
    end
  endtask

  task automatic test_gap();
    logic [7:0] exp_b [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h02};
    pulse_snd(2, 8'hFF, 16'hFFFF);
    collect(2, 600, 30);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (byte_q[k] !== exp_b[k]) begin
        bad++;
        $display("FAIL gap_byte%0d: got %h want %h", k, byte_q[k], exp_b[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (trmt_cq[k+1] - rise_cq[k] != 11) begin
        bad++;
        $display("FAIL gap_delay%0d: got %0d want 11", k, trmt_cq[k+1] - rise_cq[k]);
      end
    end
    total++;
    if (done_cnt != 1 || extra_trmt != 0) begin
      bad++;
      $display("FAIL gap_frm_done: got cnt=%0d xt=%0d want 1 0", done_cnt, extra_trmt);
    end
  endtask

  task automatic test_ignore_snd();
    logic [7:0] exp_b [4] = '{8'hA5, 8'h12, 8'h34, 8'h14};
    pulse_snd(0, 8'hA5, 16'h1234);
    fork
      collect(0, 400, 60);
      begin
        repeat (50) @(negedge clk);
        cmd = 8'h11;
        data = 16'hBEEF;
        snd_w[0] = 1'b1;
        @(negedge clk);
        snd_w[0] = 1'b0;
      end
    join
    for (int k = 0; k < 4; k++) begin
      total++;
      if (byte_q[k] !== exp_b[k]) begin
        bad++;
        $display("FAIL ignore_byte%0d: got %h want %h", k, byte_q[k], exp_b[k]);
      end
    end
    total++;
    if (byte_q.size() != 4 || extra_trmt != 0 || done_cnt != 1) begin
      bad++;
      $display("FAIL ignore_count: got n=%0d xt=%0d done=%0d want 4 0 1", byte_q.size(), extra_trmt, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4] = '{8'h3C, 8'h01, 8'h02, 8'hC0};
    bit seen = 0;
    pulse_snd(0, 8'h5A, 16'h0001);
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (frm_done_w[0]) seen = 1;
    end
    total++;
    if (!seen || trmt_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first_done: got seen=%0d trmt=%b want 1 0", seen, trmt_w[0]);
    end
    cmd = 8'h3C;
    data = 16'h0102;
    snd_w[0] = 1'b1;
    @(negedge clk);
    snd_w[0] = 1'b0;
    total++;
    if ({trmt_w[0], busy_w[0], tx_data_w[0]} !== {1'b1, 1'b1, 8'h3C}) begin
      bad++;
      $display("FAIL b2b_restart: got trmt=%b busy=%b data=%h want 1 1 3c", trmt_w[0], busy_w[0], tx_data_w[0]);
    end
    collect(0, 400, 10);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (byte_q[k] !== exp_b[k]) begin
        bad++;
        $display("FAIL b2b_byte%0d: got %h want %h", k, byte_q[k], exp_b[k]);
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL b2b_frm_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h02};
    int n_trmt = 1;
    int n_busy = 0;
    pulse_snd(0, 8'hA5, 16'h1234);
    for (int i = 0; i < 200 && n_trmt < 2; i++) begin
      @(negedge clk);
      if (trmt_w[0]) n_trmt++;
    end
    repeat (5) @(negedge clk);
    total++;
    if (n_trmt != 2 || busy_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_setup: got trmts=%0d busy=%b want 2 1", n_trmt, busy_w[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({trmt_w[0], busy_w[0], frm_done_w[0], tx_data_w[0]} !== 11'h000) begin
      bad++;
      $display("FAIL rstmid_outputs: got %h want 000", {trmt_w[0], busy_w[0], frm_done_w[0], tx_data_w[0]});
    end
    rst = 1'b0;
    n_trmt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (trmt_w[0]) n_trmt++;
      if (busy_w[0]) n_busy++;
    end
    total++;
    if (n_trmt != 0 || n_busy != 0) begin
      bad++;
      $display("FAIL rstmid_quiet: got trmt=%0d busy=%0d want 0 0", n_trmt, n_busy);
    end
    pulse_snd(0, 8'hFF, 16'hFFFF);
    collect(0, 400, 10);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (byte_q[k] !== exp_b[k]) begin
        bad++;
        $display("FAIL rstmid_byte%0d: got %h want %h", k, byte_q[k], exp_b[k]);
      end
    end
    total++;
    if (done_cnt != 1 || byte_q.size() != 4) begin
      bad++;
      $display("FAIL rstmid_frame: got done=%0d n=%0d want 1 4", done_cnt, byte_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) snd_w[i] = 1'b0;
    cmd = 8'h00;
    data = 16'h0000;
    test_reset();
    test_chksum();
    test_no_chksum();
    test_gap();
    test_ignore_snd();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
